uart_tx_scheduler: RTL and testbench

Sequences and shares the single uart_basic transmitter between two requesters.
- Calculator result path: a 16-bit result sent as a multi-byte frame.
- Echo path: single received bytes sent back to the host.
It drives tx_start/tx_data, sits between the ALU/RX controller and uart_basic, and enforces the register-settle and inter-byte delays.

---
 rtl/uart_tx_scheduler_if.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_if
//   Groups the request side (ALU result trigger, RX echo byte), the
//   uart_basic transmitter handshake and the scheduler status flags.
//
//   master : the environment (ALU / RX controller / uart_basic) side
//   slave  : the scheduler side
//
//   trigger        1-cycle pulse, capture resultado
//   resultado[16]  result word to transmit
//   echo_valid     1-cycle pulse, echo_data valid
//   echo_data[8]   received byte to echo
//   tx_busy        uart_basic transmitter busy
//   tx_start       1-cycle start pulse to uart_basic
//   tx_data[8]     byte to uart_basic
//   busy           scheduler not idle
//   result_pending result captured, frame not yet started
//   echo_overrun   sticky, echo byte dropped
//   ack_error      sticky, tx_busy did not rise in time
// ----------------------------------------------------------------------------
interface uart_tx_scheduler_if;
   logic        trigger;
   logic [15:0] resultado;
   logic        echo_valid;
   logic [7:0]  echo_data;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        result_pending;
   logic        echo_overrun;
   logic        ack_error;

   modport master (
      output trigger, resultado, echo_valid, echo_data, tx_busy,
      input  tx_start, tx_data, busy, result_pending, echo_overrun, ack_error
   );

   modport slave (
      input  trigger, resultado, echo_valid, echo_data, tx_busy,
      output tx_start, tx_data, busy, result_pending, echo_overrun, ack_error
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one uart_basic transmitter between a 16-bit calculator result
//   (multi-byte frame) and single-byte echoes of received data. Holds tx_data
//   stable for a settle time before pulsing tx_start, waits for the
//   transmitter to acknowledge and finish, then idles for an inter-byte gap.
//
//   Ports:
//     clk     system clock
//     resetN  asynchronous active-low reset
//     bus     uart_tx_scheduler_if.slave (requests, uart handshake, status)
//
//   Build option:
//     TX_ASCII_HEX_EN  defined: result frame is 4 uppercase ASCII hex digits
//                      (MS nibble first) followed by 8'h0D.
//                      undefined: raw 2-byte frame, low byte first.
// ----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int unsigned INTER_BYTE_DELAY        = 1000000,
   parameter int unsigned WAIT_FOR_REGISTER_DELAY = 100,
   parameter int unsigned ACK_TIMEOUT             = 16
) (
   input  logic               clk,
   input  logic               resetN,
   uart_tx_scheduler_if.slave bus
);

`ifdef TX_ASCII_HEX_EN
   localparam int unsigned FRAME_BYTES = 5;
`else
   localparam int unsigned FRAME_BYTES = 2;
`endif
   localparam int unsigned FRAME_W = 8 * FRAME_BYTES;

   // Counters count down to zero, so a delay of N cycles loads N-1.
   localparam logic [31:0] REG_LOAD = (WAIT_FOR_REGISTER_DELAY > 0) ?
                                      32'(WAIT_FOR_REGISTER_DELAY - 1) : 32'd0;
   localparam logic [31:0] ACK_LOAD = (ACK_TIMEOUT > 0) ?
                                      32'(ACK_TIMEOUT - 1) : 32'd0;
   localparam logic [31:0] GAP_LOAD = (INTER_BYTE_DELAY > 0) ?
                                      32'(INTER_BYTE_DELAY - 1) : 32'd0;

   typedef enum logic [2:0] {
      IDLE, REGISTER, START, WAIT_ACK, WAIT_DONE, GAP
   } state_e;

   typedef enum logic {
      SRC_ECHO   = 1'b0,
      SRC_RESULT = 1'b1
   } src_e;

   state_e               state_q, state_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;      // bytes still to send, next in [7:0]
   logic [2:0]           left_q, left_d;        // count of bytes held in frame_q
   src_e                 src_q, src_d;          // owner of the active frame
   src_e                 last_grant_q, last_grant_d;
   logic                 ack_error_q, ack_error_d;
   logic [15:0]          res_slot_q, res_slot_d;
   logic                 res_pend_q, res_pend_d;
   logic [7:0]           echo_slot_q, echo_slot_d;
   logic                 echo_full_q, echo_full_d;
   logic                 echo_overrun_q, echo_overrun_d;

   logic                 grant_res;
   logic                 grant_echo;
   logic [FRAME_W-1:0]   full_frame;

`ifdef TX_ASCII_HEX_EN
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) hex_ascii = 8'h30 + {4'h0, nib};
      else             hex_ascii = 8'h37 + {4'h0, nib};   // 10 -> 'A'
   endfunction

   // First byte on the wire sits in the low byte.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [15:0] w);
      build_frame = {8'h0D, hex_ascii(w[3:0]), hex_ascii(w[7:4]),
                     hex_ascii(w[11:8]), hex_ascii(w[15:12])};
   endfunction
`else
   function automatic logic [FRAME_W-1:0] build_frame(input logic [15:0] w);
      build_frame = w;
   endfunction
`endif

   assign full_frame = build_frame(res_slot_q);

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tx_data_d    = tx_data_q;
      frame_d      = frame_q;
      left_d       = left_q;
      src_d        = src_q;
      last_grant_d = last_grant_q;
      ack_error_d  = ack_error_q;
      grant_res    = 1'b0;
      grant_echo   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // With both slots full, the side that did not go last wins.
            grant_res  = res_pend_q && (!echo_full_q || last_grant_q == SRC_ECHO);
            grant_echo = echo_full_q && !grant_res;
            if (grant_res) begin
               tx_data_d = full_frame[7:0];
               frame_d   = full_frame >> 8;
               left_d    = 3'(FRAME_BYTES - 1);
               src_d     = SRC_RESULT;
               state_d   = REGISTER;
               cnt_d     = REG_LOAD;
            end else if (grant_echo) begin
               tx_data_d = echo_slot_q;
               frame_d   = '0;
               left_d    = 3'd0;
               src_d     = SRC_ECHO;
               state_d   = REGISTER;
               cnt_d     = REG_LOAD;
            end
         end

         REGISTER: begin
            if (cnt_q == 32'd0) state_d = START;
            else                cnt_d   = cnt_q - 32'd1;
         end

         START: begin
            state_d = WAIT_ACK;
            cnt_d   = ACK_LOAD;
         end

         WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == 32'd0) begin
               // No acknowledge: flag it and treat the byte as sent.
               ack_error_d = 1'b1;
               state_d     = GAP;
               cnt_d       = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end

         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end
         end

         GAP: begin
            if (cnt_q != 32'd0) begin
               cnt_d = cnt_q - 32'd1;
            end else if (left_q != 3'd0) begin
               tx_data_d = frame_q[7:0];
               frame_d   = frame_q >> 8;
               left_d    = left_q - 3'd1;
               state_d   = REGISTER;
               cnt_d     = REG_LOAD;
            end else begin
               last_grant_d = src_q;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Request slots
   // ------------------------------------------------------------------------
   always_comb begin
      // A trigger in the grant cycle refills the slot for the next frame.
      res_slot_d = res_slot_q;
      res_pend_d = res_pend_q && !grant_res;
      if (bus.trigger) begin
         res_slot_d = bus.resultado;
         res_pend_d = 1'b1;
      end
   end

   always_comb begin
      // The slot frees on grant, so a byte arriving that same cycle fits.
      echo_slot_d    = echo_slot_q;
      echo_full_d    = echo_full_q && !grant_echo;
      echo_overrun_d = echo_overrun_q;
      if (bus.echo_valid) begin
         if (!echo_full_d) begin
            echo_slot_d = bus.echo_data;
            echo_full_d = 1'b1;
         end else begin
            echo_overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q        <= IDLE;
         cnt_q          <= 32'd0;
         tx_data_q      <= 8'h00;
         frame_q        <= '0;
         left_q         <= 3'd0;
         src_q          <= SRC_ECHO;
         last_grant_q   <= SRC_ECHO;
         ack_error_q    <= 1'b0;
         res_slot_q     <= 16'h0000;
         res_pend_q     <= 1'b0;
         echo_slot_q    <= 8'h00;
         echo_full_q    <= 1'b0;
         echo_overrun_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tx_data_q      <= tx_data_d;
         frame_q        <= frame_d;
         left_q         <= left_d;
         src_q          <= src_d;
         last_grant_q   <= last_grant_d;
         ack_error_q    <= ack_error_d;
         res_slot_q     <= res_slot_d;
         res_pend_q     <= res_pend_d;
         echo_slot_q    <= echo_slot_d;
         echo_full_q    <= echo_full_d;
         echo_overrun_q <= echo_overrun_d;
      end
   end

   // START lasts exactly one cycle, so decoding it gives a single pulse.
   assign bus.tx_start       = (state_q == START);
   assign bus.tx_data        = tx_data_q;
   assign bus.busy           = (state_q != IDLE);
   assign bus.result_pending = res_pend_q;
   assign bus.echo_overrun   = echo_overrun_q;
   assign bus.ack_error      = ack_error_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
   localparam int IBD  = 20;
   localparam int WRD  = 5;
   localparam int ACKT = 16;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   uart_tx_scheduler_if ifc ();

   uart_tx_scheduler #(
      .INTER_BYTE_DELAY        (IBD),
      .WAIT_FOR_REGISTER_DELAY (WRD),
      .ACK_TIMEOUT             (ACKT)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (ifc.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- uart_basic model: busy 1 cycle after start, 10 cycles
   bit         model_en;
   logic       start_seen;
   logic [3:0] bcnt;
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         start_seen  <= 1'b0;
         bcnt        <= 4'd0;
         ifc.tx_busy <= 1'b0;
      end else begin
         start_seen <= ifc.tx_start && model_en;
         if (start_seen) begin
            ifc.tx_busy <= 1'b1;
            bcnt        <= 4'd9;
         end else if (bcnt != 4'd0) begin
            bcnt <= bcnt - 4'd1;
         end else begin
            ifc.tx_busy <= 1'b0;
         end
      end
   end

   // ---------------- reference model: expected byte stream
   logic [7:0] exp_q[$];
   bit         last_res;   // 1: result frame was the last one granted

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push_result(input logic [15:0] w);
`ifdef TX_ASCII_HEX_EN
      for (int i = 3; i >= 0; i--) begin
         int n;
         n = (int'(w) >> (4 * i)) % 16;
         if (n < 10) exp_q.push_back(8'(48 + n));
         else        exp_q.push_back(8'(65 + n - 10));
      end
      exp_q.push_back(8'h0D);
`else
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
`endif
   endtask

   // ---------------- monitor / scoreboard
   initial begin
      logic       prev_start;
      logic       prev_busy;
      logic [7:0] cur_byte;
      int         since_fall;
      bit         fall_seen;
      prev_start = 1'b0; prev_busy = 1'b0; cur_byte = 8'h00;
      since_fall = 0; fall_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetN) begin
            prev_start = 1'b0; prev_busy = 1'b0; fall_seen = 1'b0;
         end else begin
            if (fall_seen) since_fall++;
            if (ifc.tx_start) begin
               check("tx_start_width", prev_start, 1'b0);
               if (fall_seen) check("inter_byte_gap_ok", since_fall >= IBD, 1'b1);
               fall_seen = 1'b0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_tx_start: got tx_data 0x%02h, expected no transmission", ifc.tx_data);
               end else begin
                  check("tx_byte", ifc.tx_data, exp_q.pop_front());
               end
               cur_byte = ifc.tx_data;
            end
            if (prev_busy && !ifc.tx_busy) begin
               check("tx_data_stable", ifc.tx_data, cur_byte);
               fall_seen  = 1'b1;
               since_fall = 0;
            end
            prev_start = ifc.tx_start;
            prev_busy  = ifc.tx_busy;
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic pulse(input bit trig, input logic [15:0] r, input bit ev, input logic [7:0] e);
      @(posedge clk); #1;
      ifc.trigger = trig; ifc.resultado = r; ifc.echo_valid = ev; ifc.echo_data = e;
      @(posedge clk); #1;
      ifc.trigger = 1'b0; ifc.echo_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !ifc.busy && !ifc.result_pending) && n < 3000) begin
         @(negedge clk); n++;
      end
      if (n >= 3000) begin
         n_checks++;
         $display("FAIL %s_idle_timeout: got %0d bytes outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic wait_start(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!ifc.tx_start && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         n_checks++;
         $display("FAIL %s_start_timeout: got no tx_start, expected one", name);
      end
   endtask

   task automatic issue_result(input logic [15:0] r);
      push_result(r); last_res = 1'b1;
      pulse(1'b1, r, 1'b0, 8'h00);
   endtask

   task automatic issue_echo(input logic [7:0] e);
      exp_q.push_back(e); last_res = 1'b0;
      pulse(1'b0, 16'h0000, 1'b1, e);
   endtask

   task automatic issue_pair(input logic [15:0] r, input logic [7:0] e);
      if (!last_res) begin
         push_result(r); exp_q.push_back(e); last_res = 1'b0;
      end else begin
         exp_q.push_back(e); push_result(r); last_res = 1'b1;
      end
      pulse(1'b1, r, 1'b1, e);
   endtask

   task automatic issue_result_timed(input logic [15:0] r);
      int n;
      issue_result(r);
      @(negedge clk);
      check("result_pending_set", ifc.result_pending, 1'b1);
      n = 1;
      while (!ifc.tx_start && n < 100) begin @(negedge clk); n++; end
      check("trigger_to_start_latency", n, WRD + 2);
      check("result_pending_clear", ifc.result_pending, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"},       ifc.tx_start,       1'b0);
      check({tag, "_tx_data"},        ifc.tx_data,        8'h00);
      check({tag, "_busy"},           ifc.busy,           1'b0);
      check({tag, "_result_pending"}, ifc.result_pending, 1'b0);
      check({tag, "_echo_overrun"},   ifc.echo_overrun,   1'b0);
      check({tag, "_ack_error"},      ifc.ack_error,      1'b0);
   endtask

   // ---------------- main sequence
   initial begin
      logic [15:0] r, r2;
      logic [7:0]  e;
      int          kind, n;

      resetN = 1'b0; model_en = 1'b1; last_res = 1'b0;
      ifc.trigger = 1'b0; ifc.resultado = 16'h0000;
      ifc.echo_valid = 1'b0; ifc.echo_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      resetN = 1'b1;

      // arbitration: last_grant=ECHO, result wins
      issue_pair(16'h1234, 8'h41);
      wait_idle("pair1");

      // single result frame with latency check
`ifdef TX_ASCII_HEX_EN
      issue_result_timed(16'h0BEF);
`else
      issue_result_timed(16'hA55A);
`endif
      wait_idle("result1");
      check("busy_returns_low", ifc.busy, 1'b0);

      // arbitration: last_grant=RESULT, echo wins
      issue_pair(16'h1234, 8'h41);
      wait_idle("pair2");

      // randomized traffic
      for (int i = 0; i < 10; i++) begin
         kind = $urandom_range(0, 2);
         r    = 16'($urandom);
         e    = 8'($urandom);
         if (kind == 0)      issue_result(r);
         else if (kind == 1) issue_echo(e);
         else                issue_pair(r, e);
         wait_idle("random");
      end

      // overrun during a result frame
      r = 16'($urandom);
      issue_result(r);
      wait_start("overrun");
      exp_q.push_back(8'h31); last_res = 1'b0;
      pulse(1'b0, 16'h0000, 1'b1, 8'h31);
      repeat (2) @(posedge clk);
      pulse(1'b0, 16'h0000, 1'b1, 8'h32);
      repeat (2) @(posedge clk);
      pulse(1'b0, 16'h0000, 1'b1, 8'h33);
      @(negedge clk);
      check("echo_overrun_set", ifc.echo_overrun, 1'b1);
      wait_idle("overrun");

      // overwrite while previous frame is in its final gap
      r = 16'($urandom);
      issue_result(r);
      n = 0;
      while ((exp_q.size() != 0 || !ifc.tx_busy) && n < 1000) begin @(negedge clk); n++; end
      while (ifc.tx_busy && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) begin
         n_checks++;
         $display("FAIL overwrite_sync_timeout: got no final busy fall, expected one");
      end
      pulse(1'b1, 16'h0001, 1'b0, 8'h00);
      @(negedge clk);
      check("overwrite_pending", ifc.result_pending, 1'b1);
      check("overwrite_in_gap_busy", ifc.busy, 1'b1);
      push_result(16'h0002); last_res = 1'b1;
      pulse(1'b1, 16'h0002, 1'b0, 8'h00);
      wait_idle("overwrite");
      check("echo_overrun_sticky", ifc.echo_overrun, 1'b1);

      // ack timeout: transmitter never responds
      model_en = 1'b0;
      r = 16'($urandom);
      issue_result(r);
      wait_start("ack");
      n = 0;
      while (!ifc.ack_error && n < 100) begin @(negedge clk); n++; end
      check("ack_timeout_cycles", n, ACKT + 1);
      wait_idle("ack");
      check("ack_error_sticky", ifc.ack_error, 1'b1);
      model_en = 1'b1;

      // asynchronous reset during REGISTER
      r2 = 16'($urandom) | 16'h0011;
      pulse(1'b1, r2, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", ifc.busy, 1'b1);
      #2 resetN = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      last_res = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
      repeat (60) @(negedge clk);
      check("post_reset_idle", ifc.busy, 1'b0);

      // recovery after reset
      r = 16'($urandom);
      issue_result_timed(r);
      wait_idle("recovery");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog expired");
   end
endmodule
